compress1_pack: RTL and testbench
=================================

Name: compress1_pack

Overview:
- Kyber Compress_q(x,1) plus message-byte packing: turns a 256-coefficient polynomial into the 32-byte message m'.
- Accepts two 16-bit coefficients per transfer and emits one packed byte every 4 accepted pairs.
- Sits directly upstream of decompress1 in the decapsulation re-encryption path. Its byte stream (comp_dout, out_index, readout_ok/readout) has the same format decompress1 consumes.

Parameters:
- Q, 3329, modulus; coefficient reduction constant.
- LO, 833, lowest coefficient that compresses to bit 1.
- HI, 2496, highest coefficient that compresses to bit 1.
- NBYTES, 32, bytes per polynomial; done fires after byte NBYTES-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- set  in  1  block enable; low forces IDLE and clears the accumulator.
- readin  in  1  upstream offers a coefficient pair this cycle.
- comp_din_1  in  16  coefficient 2p.
- comp_din_2  in  16  coefficient 2p+1.
- in_index  in  8  pair index p, 0..127.
- readout  in  1  downstream takes the current byte.
- readin_ok  out  1  block can accept a pair this cycle.
- comp_dout  out  8  packed message byte.
- out_index  out  8  byte index 0..31 of comp_dout.
- readout_ok  out  1  comp_dout/out_index valid.
- done  out  1  one-cycle pulse when byte NBYTES-1 is taken.

Behaviour:
- Reset (reset=0, asynchronous): readin_ok=0, readout_ok=0, done=0, comp_dout=0, out_index=0; accumulator cleared; state IDLE.
- States:
  - IDLE: set=0; readin_ok=0.
  - RUN: accepting pairs.
  - HOLD: byte complete and output register still occupied.
  - FIN: last byte taken; done pulse.
- Transitions:
  - IDLE->RUN on set=1.
  - RUN->HOLD when the 4th pair of a byte is accepted while readout_ok=1 and readout=0.
  - HOLD->RUN when readout&readout_ok.
  - RUN->FIN when byte 31 is taken.
  - FIN->IDLE the next cycle.
  - Any state->IDLE when set=0, with the accumulator cleared.
- Transfer in: occurs on a rising edge with readin&readin_ok.
  - readin_ok=1 in RUN only.
  - It stays 1 while the output register is empty, or is being drained this cycle (readout&readout_ok).
- Compression:
  - x' = x-Q if x>=Q, else x.
  - bit = 1 iff LO<=x'<=HI.
  - Inputs >= 2Q are outside the contract; they still get a single conditional subtract and compare, with a deterministic result.
- Packing:
  - comp_din_1 bit goes to accumulator bit 2*in_index[1:0].
  - comp_din_2 bit goes to accumulator bit 2*in_index[1:0]+1.
  - Byte k holds coefficients 8k..8k+7, LSB = coefficient 8k.
- Byte completion: on the transfer where in_index[1:0]==3, the completed byte loads the output register.
  - comp_dout = accumulator bits merged with the current pair.
  - out_index = in_index[6:2]; readout_ok=1 on the next cycle.
  - Latency: 1 cycle from the 4th pair's acceptance edge to readout_ok.
- Output hold: comp_dout/out_index stay stable while readout_ok=1 and readout=0.
- Drain and refill: readout&readout_ok clears readout_ok next cycle, unless a new byte completes in the same cycle. In that case the register reloads and readout_ok stays 1 (back-to-back bytes, no bubble).
- Accumulator: cleared after each byte completion. Pairs need not arrive in order within a byte, but must all arrive before the pair with in_index[1:0]==3.
- done: 1 in FIN for exactly one cycle, then 0.
- Mid-operation events:
  - reset low mid-polynomial discards everything immediately.
  - set low mid-polynomial discards the partial byte and the held byte (readout_ok->0 next edge).
  - readin while readin_ok=0 is ignored (no transfer).

Test Plan:
- Threshold sweep: pairs (0,832), (833,1664), (2496,2497), (3328,3329) on in_index 0..3 -> comp_dout=8'b00011100, out_index=0, one cycle after the 4th pair.
- Full polynomial, all pairs (1665,0), readout held 1 -> 32 bytes of 8'h55, out_index 0..31 with no bubbles; done pulses once after byte 31.
- Backpressure: byte 0 complete (8'hFF from all-1665 coefficients), readout=0 for 10 cycles -> comp_dout stays 8'hFF, readin_ok=0 once byte 1's 4th pair completes; releasing readout delivers byte 1 the next cycle.
- Random readout (50%) over 256 random coefficients in [0,3328] -> byte stream equals a software Compress1 model; no byte lost or duplicated.
- Reset mid-stream: reset=0 after 10 pairs -> all outputs 0 asynchronously; after reset=1 and set=1, a fresh stream from in_index 0 produces correct byte 0.
- Chain with decompress1: comp_dout/out_index into decompress1 -> decompressed coefficients are 1665 exactly where input x' was in [833,2496], else 0.

Source files
------------

// File: rtl/compress1_pack.sv
// Kyber Compress_q(x,1) with message-byte packing.
// Two coefficients per transfer, one packed byte per four transfers.
module compress1_pack #(
   parameter int unsigned Q      = 3329,
   parameter int unsigned LO     = 833,
   parameter int unsigned HI     = 2496,
   parameter int unsigned NBYTES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set,
   input  logic        readin,
   input  logic [15:0] comp_din_1,
   input  logic [15:0] comp_din_2,
   input  logic [7:0]  in_index,
   input  logic        readout,
   output logic        readin_ok,
   output logic [7:0]  comp_dout,
   output logic [7:0]  out_index,
   output logic        readout_ok,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;

   state_t      state_q, state_d;
   logic [7:0]  acc_q, acc_d;
   logic [5:0]  pidx_q, pidx_d;
   logic [7:0]  dout_q, dout_d;
   logic [7:0]  oidx_q, oidx_d;
   logic        rok_q, rok_d;
   logic        done_q, done_d;

   logic [1:0]  pair;
   logic [2:0]  sh;
   logic [7:0]  mask;
   logic [7:0]  merged;
   logic        xfer;
   logic        drain;
   logic        complete;
   logic        last;

   function automatic logic comp1(input logic [15:0] x);
      logic [15:0] xr;
      xr = (x >= 16'(Q)) ? x - 16'(Q) : x;
      return (xr >= 16'(LO)) && (xr <= 16'(HI));
   endfunction

   assign readin_ok  = (state_q == RUN);
   assign comp_dout  = dout_q;
   assign out_index  = oidx_q;
   assign readout_ok = rok_q;
   assign done       = done_q;

   always_comb begin
      pair     = {comp1(comp_din_2), comp1(comp_din_1)};
      sh       = {in_index[1:0], 1'b0};
      mask     = 8'h03 << sh;
      merged   = (acc_q & ~mask) | ({6'b0, pair} << sh);
      xfer     = readin && readin_ok;
      drain    = readout && rok_q;
      complete = xfer && (in_index[1:0] == 2'd3);
      last     = (oidx_q == 8'(NBYTES - 1));

      state_d = state_q;
      acc_d   = acc_q;
      pidx_d  = pidx_q;
      dout_d  = dout_q;
      oidx_d  = oidx_q;
      rok_d   = rok_q;
      done_d  = 1'b0;

      if (!set) begin
         state_d = IDLE;
         acc_d   = 8'h00;
         rok_d   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
               if (drain) rok_d = 1'b0;
               if (complete) begin
                  // Output register free or freeing now: load without a bubble.
                  if (!rok_q || drain) begin
                     dout_d = merged;
                     oidx_d = {2'b00, in_index[7:2]};
                     rok_d  = 1'b1;
                     acc_d  = 8'h00;
                  end else begin
                     acc_d   = merged;
                     pidx_d  = in_index[7:2];
                     state_d = HOLD;
                  end
               end else begin
                  if (xfer) acc_d = merged;
                  if (drain && last) begin
                     state_d = FIN;
                     done_d  = 1'b1;
                  end
               end
            end
            HOLD: begin
               // The accumulator keeps the finished byte until the slot drains.
               if (drain) begin
                  dout_d  = acc_q;
                  oidx_d  = {2'b00, pidx_q};
                  acc_d   = 8'h00;
                  state_d = RUN;
               end
            end
            FIN: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         acc_q   <= 8'h00;
         pidx_q  <= 6'd0;
         dout_q  <= 8'h00;
         oidx_q  <= 8'h00;
         rok_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         pidx_q  <= pidx_d;
         dout_q  <= dout_d;
         oidx_q  <= oidx_d;
         rok_q   <= rok_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_compress1_pack.sv
// Directed and random checks for compress1_pack.
module tb_compress1_pack;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        set = 1'b0;
   logic        readin = 1'b0;
   logic [15:0] din1 = '0;
   logic [15:0] din2 = '0;
   logic [7:0]  in_index = '0;
   logic        readout = 1'b0;
   logic        readin_ok;
   logic [7:0]  comp_dout;
   logic [7:0]  out_index;
   logic        readout_ok;
   logic        done;

   int errors = 0;
   int checks = 0;

   logic        mon_en = 1'b0;
   logic [15:0] got[$];
   int          done_cnt = 0;
   logic        sending_done;
   logic [15:0] coef[256];

   compress1_pack dut (
      .clk(clk),
      .reset(reset),
      .set(set),
      .readin(readin),
      .comp_din_1(din1),
      .comp_din_2(din2),
      .in_index(in_index),
      .readout(readout),
      .readin_ok(readin_ok),
      .comp_dout(comp_dout),
      .out_index(out_index),
      .readout_ok(readout_ok),
      .done(done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mon_en) begin
         if (readout && readout_ok) got.push_back({out_index, comp_dout});
         if (done) done_cnt++;
      end
   end

   task automatic send_pair(input int p, input logic [15:0] a,
                            input logic [15:0] b);
      bit ok;
      readin = 1'b1;
      in_index = p[7:0];
      din1 = a;
      din2 = b;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (readin_ok) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_pair idx=%0d readin_ok=%b required 1", p, readin_ok);
      end else begin
         @(posedge clk);
         #1;
      end
      readin = 1'b0;
   endtask

   task automatic restart();
      set = 1'b0;
      readin = 1'b0;
      readout = 1'b0;
      repeat (2) @(posedge clk);
      #1 set = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      set = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({readin_ok, readout_ok, done, comp_dout, out_index} !== 19'd0) begin
         errors++;
         $display("FAIL reset ok=%b rok=%b done=%b dout=%h idx=%h required all 0",
                  readin_ok, readout_ok, done, comp_dout, out_index);
      end
      reset = 1'b1;
   endtask

   task automatic test_threshold();
      restart();
      send_pair(0, 16'd0, 16'd832);
      send_pair(1, 16'd833, 16'd1664);
      send_pair(2, 16'd2496, 16'd2497);
      checks++;
      if (readout_ok !== 1'b0) begin
         errors++;
         $display("FAIL thr_early readout_ok=%b required 0", readout_ok);
      end
      send_pair(3, 16'd3328, 16'd3329);
      checks++;
      if (readout_ok !== 1'b1) begin
         errors++;
         $display("FAIL thr_valid readout_ok=%b required 1", readout_ok);
      end
      checks++;
      if (comp_dout !== 8'b00011100) begin
         errors++;
         $display("FAIL thr_byte comp_dout=%b required 00011100", comp_dout);
      end
      checks++;
      if (out_index !== 8'd0) begin
         errors++;
         $display("FAIL thr_index out_index=%0d required 0", out_index);
      end
      checks++;
      if (readin_ok !== 1'b1) begin
         errors++;
         $display("FAIL thr_readin_ok readin_ok=%b required 1", readin_ok);
      end
   endtask

   task automatic test_full();
      restart();
      readout = 1'b1;
      got.delete();
      done_cnt = 0;
      mon_en = 1'b1;
      for (int p = 0; p < 128; p++) send_pair(p, 16'd1665, 16'd0);
      repeat (10) @(posedge clk);
      #1 mon_en = 1'b0;
      readout = 1'b0;
      checks++;
      if (got.size() != 32) begin
         errors++;
         $display("FAIL full_count bytes=%0d required 32", got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
         checks++;
         if (got[k] !== {k[7:0], 8'h55}) begin
            errors++;
            $display("FAIL full_byte%0d got=%h required %h", k, got[k], {k[7:0], 8'h55});
         end
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL full_done pulses=%0d required 1", done_cnt);
      end
   endtask

   task automatic test_backpressure();
      restart();
      for (int p = 0; p < 4; p++) send_pair(p, 16'd1665, 16'd1665);
      for (int p = 4; p < 8; p++) send_pair(p, 16'd1665, 16'd0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if ({readin_ok, readout_ok, out_index, comp_dout} !== {1'b0, 1'b1, 8'd0, 8'hFF}) begin
            errors++;
            $display("FAIL bp_hold%0d ok=%b rok=%b idx=%0d dout=%h required 0 1 0 ff",
                     c, readin_ok, readout_ok, out_index, comp_dout);
         end
      end
      @(posedge clk);
      #1 readout = 1'b1;
      @(posedge clk);
      #1 readout = 1'b0;
      checks++;
      if ({readout_ok, out_index, comp_dout} !== {1'b1, 8'd1, 8'h55}) begin
         errors++;
         $display("FAIL bp_release rok=%b idx=%0d dout=%h required 1 1 55",
                  readout_ok, out_index, comp_dout);
      end
      checks++;
      if (readin_ok !== 1'b1) begin
         errors++;
         $display("FAIL bp_resume readin_ok=%b required 1", readin_ok);
      end
   endtask

   task automatic test_random();
      logic [7:0] eb;
      logic [7:0] db;
      int unsigned x;
      restart();
      for (int i = 0; i < 256; i++) coef[i] = 16'($urandom_range(0, 3328));
      got.delete();
      done_cnt = 0;
      mon_en = 1'b1;
      sending_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 128; p++) send_pair(p, coef[2*p], coef[2*p+1]);
            sending_done = 1'b1;
         end
         begin
            while (!sending_done) begin
               @(posedge clk);
               #1 readout = 1'($urandom_range(0, 1));
            end
         end
      join
      readout = 1'b1;
      repeat (10) @(posedge clk);
      #1 mon_en = 1'b0;
      readout = 1'b0;
      checks++;
      if (got.size() != 32) begin
         errors++;
         $display("FAIL rnd_count bytes=%0d required 32", got.size());
      end
      for (int k = 0; k < got.size(); k++) begin
         for (int j = 0; j < 8; j++) begin
            x = coef[8*k+j];
            eb[j] = 1'(((2 * x + 1664) / 3329) & 1);
            db[j] = ((got[k][j] ? 1665 : 0) == ((x >= 833 && x <= 2496) ? 1665 : 0));
         end
         checks++;
         if (got[k] !== {k[7:0], eb}) begin
            errors++;
            $display("FAIL rnd_byte%0d got=%h required %h", k, got[k], {k[7:0], eb});
         end
         checks++;
         if (db !== 8'hFF) begin
            errors++;
            $display("FAIL rnd_decomp%0d agree=%b required 11111111", k, db);
         end
      end
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL rnd_done pulses=%0d required 1", done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      restart();
      readout = 1'b1;
      for (int p = 0; p < 10; p++) send_pair(p, 16'd1665, 16'd1665);
      checks++;
      if ({out_index, comp_dout} !== {8'd1, 8'hFF}) begin
         errors++;
         $display("FAIL mid_before idx=%0d dout=%h required 1 ff", out_index, comp_dout);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({readin_ok, readout_ok, done, comp_dout, out_index} !== 19'd0) begin
         errors++;
         $display("FAIL mid_async ok=%b rok=%b done=%b dout=%h idx=%h required all 0",
                  readin_ok, readout_ok, done, comp_dout, out_index);
      end
      readout = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      for (int p = 0; p < 4; p++) send_pair(p, 16'd0, 16'd1665);
      checks++;
      if ({readout_ok, out_index, comp_dout} !== {1'b1, 8'd0, 8'hAA}) begin
         errors++;
         $display("FAIL mid_fresh rok=%b idx=%0d dout=%h required 1 0 aa",
                  readout_ok, out_index, comp_dout);
      end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_full();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
